sram_march_bist_ctrl: RTL and testbench
=======================================

Name: sram_march_bist_ctrl

Overview:
- March C- BIST engine that drives the BIST port of the 1-port SRAM macros (512x16 default) and checks read data returned on the macro DOUT.
- Sits directly upstream of the macro's A_BIST_* pins; its bist_en_o steers the macro from the functional port to the BIST port.
- Reports pass/fail plus first-failure address and March element to the test/JTAG register block.

Parameters:
- ADDR_W, 9, SRAM address width; depth = 2**ADDR_W.
- DATA_W, 16, SRAM data width; also bit-mask width.

Ports:
- clk_i  in  1  clock; also drives the macro A_BIST_CLK.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  one-cycle start pulse; ignored unless in IDLE or DONE.
- busy_o  out  1  high while in RUN or DRAIN.
- done_o  out  1  high in DONE until the next start_i.
- fail_o  out  1  sticky mismatch flag; cleared on start_i.
- fail_addr_o  out  ADDR_W  address of first mismatch.
- fail_elem_o  out  3  March element (0..5) of first mismatch.
- bist_en_o  out  1  to A_BIST_EN.
- bist_men_o  out  1  to A_BIST_MEN.
- bist_wen_o  out  1  to A_BIST_WEN.
- bist_ren_o  out  1  to A_BIST_REN.
- bist_addr_o  out  ADDR_W  to A_BIST_ADDR.
- bist_din_o  out  DATA_W  to A_BIST_DIN.
- bist_bm_o  out  DATA_W  to A_BIST_BM.
- dout_i  in  DATA_W  from A_DOUT.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start_i -> RUN. On that edge: clear fail_o, fail_addr_o, fail_elem_o, done_o; set elem=0, op=0, addr=0.
  - RUN -> DRAIN after the final op (M5 read of the last address).
  - DRAIN -> DONE after one cycle.
- March sequence (all ops registered outputs, one op per cycle, bist_men_o=1 throughout RUN):
  - M0 up (w0)
  - M1 up (r0,w1)
  - M2 up (r1,w0)
  - M3 down (r0,w1)
  - M4 down (r1,w0)
  - M5 up (r0)
  - Data pattern: 0 = all zeros, 1 = all ones.
- Write op: wen=1, ren=0, din=pattern, bm=all ones.
- Read op: ren=1, wen=0; din and bm = 0.
- Address sequencing:
  - Up elements run 0..2**ADDR_W-1; down elements run 2**ADDR_W-1..0.
  - Within a two-op element, the address advances after the second op.
  - At the terminal address, elem increments and addr loads the start value of the next element. No wrap-around glitch cycle.
- Total ops: 10*depth (5120 at default).
- bist_en_o: high in RUN and DRAIN; low in IDLE and DONE.
- Timing: start_i sampled at edge k. The first op is presented from edge k and sampled by the macro at edge k+1. The last op is sampled at edge k+5120. done_o rises at edge k+5122.
- Read check pipeline (1 cycle):
  - When a read is issued, register cmp_vld, expected pattern, addr and elem.
  - At the next edge, compare dout_i with the expected value; dout_i is ignored when cmp_vld=0.
  - DRAIN exists only to complete the final compare.
- Failure capture:
  - On the first mismatch, set fail_o and capture addr/elem.
  - Later mismatches do not overwrite the capture.
  - A mismatch and the RUN->DRAIN transition on the same edge are both honoured.
- start_i while busy_o=1 is ignored.
- Reset mid-run: immediate return to IDLE with all outputs 0, so bist_en_o drops asynchronously and the macro returns to the functional port.

Optional Feature:
- Macro: SRAM_BIST_STOP_ON_FAIL_EN.
- With the macro: the first mismatch forces RUN/DRAIN -> DONE on the same edge. SRAM control outputs go to 0 and the remaining ops are skipped.
- Without the macro: the full 10N sequence always runs; fail_o stays sticky.

Decomposition:
- Shared package sram_bist_pkg:
  - March element enum (M0..M5, 3-bit)
  - FSM state enum
  - per-element constant tables: direction, op count, read pattern, write pattern
- One natural sub-module, sram_bist_addr_gen: up/down address counter with load, step and terminal-count output.

Test Plan:
- Fault-free behavioural SRAM model, start_i pulse -> busy_o for 5122 cycles, done_o=1, fail_o=0, bist_en_o low after DONE.
- Stuck-at-1 injected on bit 3 of address 0x0A5 -> fail_o=1, fail_addr_o=0x0A5, fail_elem_o=1.
- Stuck-at-0 injected on bit 15 of address 0x1FF -> fail_addr_o=0x1FF, fail_elem_o=2.
- Probe bist_addr_o at element boundaries -> M2 ends at 0x1FF, the next cycle shows M3 at 0x1FF with ren=1; M4 ends at 0x000, the next cycle shows M5 at 0x000.
- rst_i asserted at cycle 2000 of the run -> all outputs 0 immediately; a new start_i then completes with fail_o=0.
- start_i pulsed mid-run -> no restart, done_o still at cycle 5122. With SRAM_BIST_STOP_ON_FAIL_EN and a fault at 0x010 -> done_o one cycle after the M1 read of 0x010, bist_men_o=0 thereafter.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg
// Shared types and per-element constant tables for the March C- SRAM BIST
// engine (sram_march_bist_ctrl) and its address generator.
//   march_elem_e : March element M0..M5 (3-bit)
//   bist_state_e : controller FSM state
//   elem_*       : direction / op-count / data-pattern lookups per element
package sram_bist_pkg;

  typedef enum logic [2:0] {
    M0 = 3'd0,  // up   (w0)
    M1 = 3'd1,  // up   (r0,w1)
    M2 = 3'd2,  // up   (r1,w0)
    M3 = 3'd3,  // down (r0,w1)
    M4 = 3'd4,  // down (r1,w0)
    M5 = 3'd5   // up   (r0)
  } march_elem_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // One bit per element code, indexed by the element value; codes 6/7 unused.
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;  // M3, M4 walk downwards
  localparam logic [7:0] ELEM_TWO_OP = 8'b0001_1110;  // M1..M4 are read+write
  localparam logic [7:0] ELEM_RD_PAT = 8'b0001_0100;  // M2, M4 expect ones
  localparam logic [7:0] ELEM_WR_PAT = 8'b0000_1010;  // M1, M3 write ones

  function automatic logic elem_is_down(input march_elem_e e);
    return ELEM_DOWN[e];
  endfunction

  function automatic logic elem_is_two_op(input march_elem_e e);
    return ELEM_TWO_OP[e];
  endfunction

  function automatic logic elem_rd_pat(input march_elem_e e);
    return ELEM_RD_PAT[e];
  endfunction

  function automatic logic elem_wr_pat(input march_elem_e e);
    return ELEM_WR_PAT[e];
  endfunction

  // Two-op elements read first and write second; of the single-op
  // elements only M0 writes.
  function automatic logic elem_op_is_write(input march_elem_e e, input logic op);
    return elem_is_two_op(e) ? op : (e == M0);
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// sram_bist_addr_gen
// Up/down address counter for the March BIST engine.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   load_i         : load load_val_i (has priority over step_i)
//   load_val_i     : value to load
//   step_i         : advance one address in the direction given by down_i
//   down_i         : 1 = count down, 0 = count up
//   addr_nxt_o     : address the counter holds after the next edge
//   tc_o           : current address is the last one for the direction
module sram_bist_addr_gen
#(
  parameter int ADDR_W = 9
)
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_nxt_o,
  output logic              tc_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Next-address selection: load, step or hold.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - {{(ADDR_W-1){1'b0}}, 1'b1})
                      : (addr_q + {{(ADDR_W-1){1'b0}}, 1'b1});
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= {ADDR_W{1'b0}};
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_nxt_o = addr_d;
  assign tc_o       = down_i ? (addr_q == {ADDR_W{1'b0}}) : (addr_q == {ADDR_W{1'b1}});

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// sram_march_bist_ctrl
// March C- BIST engine driving the BIST port of a 1-port SRAM macro and
// checking read data returned on DOUT.
//   clk_i, rst_i      : clock (also the macro BIST clock), async active-high reset
//   start_i           : start pulse, accepted in IDLE or DONE only
//   busy_o / done_o   : RUN or DRAIN / finished (held until next start)
//   fail_o            : sticky mismatch flag, with fail_addr_o / fail_elem_o
//                       holding the first mismatch
//   bist_*_o          : registered macro BIST controls (EN, MEN, WEN, REN,
//                       ADDR, DIN, BM)
//   dout_i            : macro read data, valid one cycle after the read is sampled
// Optional build macro SRAM_BIST_STOP_ON_FAIL_EN: the first mismatch ends the
// run immediately (straight to DONE, macro controls to 0).
module sram_march_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
)
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [2:0]        fail_elem_o,
  output logic              bist_en_o,
  output logic              bist_men_o,
  output logic              bist_wen_o,
  output logic              bist_ren_o,
  output logic [ADDR_W-1:0] bist_addr_o,
  output logic [DATA_W-1:0] bist_din_o,
  output logic [DATA_W-1:0] bist_bm_o,
  input  logic [DATA_W-1:0] dout_i
);

  bist_state_e       state_q, state_d;
  march_elem_e       elem_q, elem_d;
  logic              op_q, op_d;
  // Set for the one cycle after the last op has been sampled, so the final
  // read reaches the compare stage while still in RUN.
  logic              seq_end_q, seq_end_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  march_elem_e       fail_elem_q, fail_elem_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic              cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  march_elem_e       cmp_elem_q, cmp_elem_d;
  logic              en_q, en_d;
  logic              men_q, men_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] bm_q, bm_d;

  logic              ag_load_s;
  logic [ADDR_W-1:0] ag_load_val_s;
  logic              ag_step_s;
  logic [ADDR_W-1:0] ag_addr_nxt_s;
  logic              ag_tc_s;
  logic              mismatch_s;
  logic              capture_s;
  logic              op_wr_s;

  sram_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ag_load_s),
    .load_val_i (ag_load_val_s),
    .step_i     (ag_step_s),
    .down_i     (elem_is_down(elem_q)),
    .addr_nxt_o (ag_addr_nxt_s),
    .tc_o       (ag_tc_s)
  );

  assign mismatch_s = cmp_vld_q && (dout_i != {DATA_W{cmp_exp_q}});
  assign capture_s  = mismatch_s && !fail_q &&
                      ((state_q == ST_RUN) || (state_q == ST_DRAIN));

  // Next state, op sequencing, failure capture and next macro controls.
  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    op_d          = op_q;
    seq_end_d     = seq_end_q;
    done_d        = done_q;
    ag_load_s     = 1'b0;
    ag_load_val_s = {ADDR_W{1'b0}};
    ag_step_s     = 1'b0;

    if (capture_s) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end else begin
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          elem_d      = M0;
          op_d        = 1'b0;
          seq_end_d   = 1'b0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = {ADDR_W{1'b0}};
          fail_elem_d = M0;
          ag_load_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (seq_end_q) begin
          state_d   = ST_DRAIN;
          seq_end_d = 1'b0;
        end else if (elem_is_two_op(elem_q) && (op_q == 1'b0)) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (ag_tc_s) begin
            ag_load_s = 1'b1;
            if (elem_q == M5) begin
              seq_end_d = 1'b1;
            end else begin
              // Jump straight to the next element's first address.
              elem_d        = march_elem_e'(elem_q + 3'd1);
              ag_load_val_s = elem_is_down(elem_d) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
            end
          end else begin
            ag_step_s = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    if (capture_s) begin
      state_d   = ST_DONE;
      done_d    = 1'b1;
      seq_end_d = 1'b0;
      elem_d    = M0;
      op_d      = 1'b0;
      ag_load_s = 1'b1;
      ag_step_s = 1'b0;
    end else begin
      state_d = state_d;
    end
`endif

    // The read being presented now is sampled by the macro at this edge;
    // its data is compared one cycle later.
    cmp_vld_d  = ren_q && (state_d == ST_RUN);
    cmp_exp_d  = elem_rd_pat(elem_q);
    cmp_addr_d = addr_q;
    cmp_elem_d = elem_q;

    busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    en_d    = busy_d;
    men_d   = (state_d == ST_RUN);
    op_wr_s = elem_op_is_write(elem_d, op_d);
    if ((state_d == ST_RUN) && !seq_end_d) begin
      wen_d  = op_wr_s;
      ren_d  = !op_wr_s;
      addr_d = ag_addr_nxt_s;
      din_d  = op_wr_s ? {DATA_W{elem_wr_pat(elem_d)}} : {DATA_W{1'b0}};
      bm_d   = op_wr_s ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    end else begin
      wen_d  = 1'b0;
      ren_d  = 1'b0;
      addr_d = {ADDR_W{1'b0}};
      din_d  = {DATA_W{1'b0}};
      bm_d   = {DATA_W{1'b0}};
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      elem_q      <= M0;
      op_q        <= 1'b0;
      seq_end_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= {ADDR_W{1'b0}};
      fail_elem_q <= M0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= {ADDR_W{1'b0}};
      cmp_elem_q  <= M0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      din_q       <= {DATA_W{1'b0}};
      bm_q        <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      seq_end_q   <= seq_end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign bist_en_o   = en_q;
  assign bist_men_o  = men_q;
  assign bist_wen_o  = wen_q;
  assign bist_ren_o  = ren_q;
  assign bist_addr_o = addr_q;
  assign bist_din_o  = din_q;
  assign bist_bm_o   = bm_q;

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// tb_sram_march_bist_ctrl
// Directed bench for sram_march_bist_ctrl with a behavioural 512x16 SRAM
// (synchronous read, bit-masked write) and a single-address stuck-at fault.
// Expectations follow the build macro SRAM_BIST_STOP_ON_FAIL_EN when defined.
module tb_sram_march_bist_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic              busy_o, done_o, fail_o;
  logic [ADDR_W-1:0] fail_addr_o;
  logic [2:0]        fail_elem_o;
  logic              bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
  logic [ADDR_W-1:0] bist_addr_o;
  logic [DATA_W-1:0] bist_din_o, bist_bm_o;
  logic [DATA_W-1:0] dout = 16'h0000;

  logic [DATA_W-1:0] mem [0:511];
  logic [ADDR_W-1:0] flt_addr = 9'h000;
  logic [DATA_W-1:0] flt_sa1  = 16'h0000;
  logic [DATA_W-1:0] flt_sa0  = 16'h0000;

  int n_checks = 0;
  int n_errors = 0;
  int done_cyc;
  int busy_cyc;

  sram_march_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .fail_elem_o (fail_elem_o),
    .bist_en_o   (bist_en_o),
    .bist_men_o  (bist_men_o),
    .bist_wen_o  (bist_wen_o),
    .bist_ren_o  (bist_ren_o),
    .bist_addr_o (bist_addr_o),
    .bist_din_o  (bist_din_o),
    .bist_bm_o   (bist_bm_o),
    .dout_i      (dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macro, BIST port only; fault applied on read.
  always @(posedge clk) begin
    if (bist_en_o && bist_men_o) begin
      if (bist_wen_o)
        mem[bist_addr_o] <= (mem[bist_addr_o] & ~bist_bm_o) | (bist_din_o & bist_bm_o);
      if (bist_ren_o)
        dout <= (bist_addr_o == flt_addr) ? ((mem[bist_addr_o] | flt_sa1) & ~flt_sa0)
                                          : mem[bist_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {EN, MEN, WEN, REN, 3'b0, ADDR[8:0], DIN[15:0]}
  function automatic logic [31:0] op_word();
    return {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o, 3'b000, bist_addr_o, bist_din_o};
  endfunction

  // Op i is presented in cycle i after the start edge.
  task automatic probe_at(input int i);
    case (i)
      0: begin
        check("m0_first_op", op_word(), 32'hE000_0000);
        check("m0_first_bm", {16'h0000, bist_bm_o}, 32'h0000_FFFF);
        check("busy_at_start", {31'd0, busy_o}, 32'd1);
      end
      512:  check("m1_first_r0", op_word(), 32'hD000_0000);
      513:  check("m1_first_w1", op_word(), 32'hE000_FFFF);
      514:  check("m1_read_bm", {16'h0000, bist_bm_o}, 32'h0000_0000);
      2559: check("m2_last_w0", op_word(), 32'hE1FF_0000);
      2560: check("m3_first_r0", op_word(), 32'hD1FF_0000);
      4607: check("m4_last_w0", op_word(), 32'hE000_0000);
      4608: check("m5_first_r0", op_word(), 32'hD000_0000);
      5119: check("m5_last_r0", op_word(), 32'hD1FF_0000);
      5120: check("run_tail", op_word(), 32'hC000_0000);
      5121: check("drain", op_word(), 32'h8000_0000);
      default: ;
    endcase
  endtask

  task automatic run_bist(input bit probe, input int restart_at, input int rst_at,
                          output int dcyc, output int bcyc);
    dcyc = -1;
    bcyc = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (done_o) begin
        dcyc = i;
        break;
      end
      if (busy_o) bcyc++;
      if (probe) probe_at(i);
      start_i = (i == restart_at);
      if (i == rst_at) begin
        rst_i = 1'b1;
        #1;
        check("rst_ctrl", {26'd0, busy_o, done_o, bist_en_o, bist_men_o, bist_wen_o, bist_ren_o}, 32'd0);
        check("rst_addr_din", {7'd0, bist_addr_o, bist_din_o}, 32'd0);
        check("rst_bm_fail", {4'd0, bist_bm_o, fail_o, fail_addr_o, fail_elem_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        dcyc = -2;
        start_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  task automatic set_fault(input logic [8:0] a, input logic [15:0] s1, input logic [15:0] s0);
    flt_addr = a;
    flt_sa1  = s1;
    flt_sa0  = s0;
  endtask

  initial begin
    // Reset state
    #23;
    check("reset_ctrl", {26'd0, busy_o, done_o, fail_o, bist_en_o, bist_men_o, bist_wen_o}, 32'd0);
    check("reset_ren_addr", {22'd0, bist_ren_o, bist_addr_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_en", {31'd0, bist_en_o}, 32'd0);

    // Fault-free run with element-boundary probes and a start pulse mid-run
    run_bist(1'b1, 1000, -1, done_cyc, busy_cyc);
    check("clean_done_cycle", done_cyc, 32'd5122);
    check("clean_busy_cycles", busy_cyc, 32'd5122);
    check("clean_fail", {31'd0, fail_o}, 32'd0);
    check("clean_after_done", op_word(), 32'h0000_0000);
    check("clean_busy_low", {31'd0, busy_o}, 32'd0);

    // Stuck-at-1 bit 3 at 0x0A5: first seen by the M1 r0 read
    set_fault(9'h0A5, 16'h0008, 16'h0000);
    run_bist(1'b0, -1, -1, done_cyc, busy_cyc);
    check("sa1_fail", {31'd0, fail_o}, 32'd1);
    check("sa1_addr", {23'd0, fail_addr_o}, 32'h0A5);
    check("sa1_elem", {29'd0, fail_elem_o}, 32'd1);
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    check("sa1_done_cycle", done_cyc, 32'd844);
`else
    check("sa1_done_cycle", done_cyc, 32'd5122);
`endif

    // Stuck-at-0 bit 15 at 0x1FF: first seen by the M2 r1 read
    set_fault(9'h1FF, 16'h0000, 16'h8000);
    run_bist(1'b0, -1, -1, done_cyc, busy_cyc);
    check("sa0_fail", {31'd0, fail_o}, 32'd1);
    check("sa0_addr", {23'd0, fail_addr_o}, 32'h1FF);
    check("sa0_elem", {29'd0, fail_elem_o}, 32'd2);
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    check("sa0_done_cycle", done_cyc, 32'd2560);
`else
    check("sa0_done_cycle", done_cyc, 32'd5122);
`endif

    // Stuck-at-1 bit 0 at 0x010
    set_fault(9'h010, 16'h0001, 16'h0000);
    run_bist(1'b0, -1, -1, done_cyc, busy_cyc);
    check("f010_addr", {23'd0, fail_addr_o}, 32'h010);
    check("f010_elem", {29'd0, fail_elem_o}, 32'd1);
    check("f010_men_off", {31'd0, bist_men_o}, 32'd0);
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
    check("f010_done_cycle", done_cyc, 32'd546);
`else
    check("f010_done_cycle", done_cyc, 32'd5122);
`endif

    // Reset in cycle 2000 of a clean run, then a full clean rerun
    set_fault(9'h000, 16'h0000, 16'h0000);
    run_bist(1'b0, -1, 2000, done_cyc, busy_cyc);
    check("rst_aborted", done_cyc, 32'hFFFF_FFFE);
    check("rst_idle_en", {31'd0, bist_en_o}, 32'd0);
    run_bist(1'b0, -1, -1, done_cyc, busy_cyc);
    check("rerun_done_cycle", done_cyc, 32'd5122);
    check("rerun_fail", {31'd0, fail_o}, 32'd0);
    check("rerun_done", {31'd0, done_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
